fetch_inst_buffer: RTL and testbench

//   Credit-managed instruction buffer between instruction fetch (AXI4-Lite AR/R) and decode.

---
 rtl/fetch_inst_buffer.sv | 131 +++++++++++++
 tb/tb_fetch_inst_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_buffer.sv
// rtl/fetch_inst_buffer.sv - credit-managed instruction queue between AXI4-Lite fetch and decode
// Tracks live and stale in-flight reads so a flush can drop responses to redirected fetches.
module fetch_inst_buffer #(
    parameter int WIDTH   = 97,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 4,
    parameter int BYPASS  = 0,
    parameter int CW      = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             rsp_valid,
    input  logic [WIDTH-1:0] rsp_data,
    input  logic             flush,
    input  logic             ren,
    output logic             rok,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    live_out,
    output logic [CW-1:0]    stale_out,
    output logic             rsp_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_W   = (CW + 1)'(DEPTH);
    localparam logic [CW:0] MAX_OUT_W = (CW + 1)'(MAX_OUT);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    live_q, live_d;
    logic [CW-1:0]    stale_q, stale_d;
    logic             rsp_err_q, rsp_err_d;

    logic [CW:0] occ_sum;
    logic [CW:0] out_sum;
    logic        head_valid;
    logic        rsp_drop;
    logic        rsp_enq;
    logic        rsp_spur;
    logic        bypass_hit;
    logic        req_fire;
    logic        pop;
    logic        store;

    assign occ_sum = {1'b0, count_q} + {1'b0, live_q};
    assign out_sum = {1'b0, live_q} + {1'b0, stale_q};

    // Stale reads absorb responses first: they were issued before any live read.
    always_comb begin
        head_valid = (count_q != '0) && !flush;
        rsp_drop   = rsp_valid && (stale_q != '0);
        rsp_enq    = rsp_valid && (stale_q == '0) && (live_q != '0);
        rsp_spur   = rsp_valid && (stale_q == '0) && (live_q == '0);
        bypass_hit = (BYPASS != 0) && (count_q == '0) && !flush && rsp_enq && ren;
        req_ready  = RSTN && !flush && (occ_sum < DEPTH_W) && (out_sum < MAX_OUT_W);
        req_fire   = req_valid && req_ready;
        pop        = ren && head_valid;
        store      = rsp_enq && !bypass_hit && !flush;
        rok        = head_valid || bypass_hit;
    end

    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        live_d    = live_q;
        stale_d   = stale_q;
        rsp_err_d = rsp_err_q || rsp_spur;
        if (flush) begin
            // Everything in flight becomes stale, minus the beat arriving right now.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            live_d   = '0;
            stale_d  = stale_q + live_q - CW'(rsp_drop || rsp_enq);
        end else begin
            if (store) begin
                mem_d[wr_ptr_q] = rsp_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(store) - CW'(pop);
            live_d  = live_q + CW'(req_fire) - CW'(rsp_enq);
            stale_d = stale_q - CW'(rsp_drop);
        end
    end

    always_comb begin
        rdata = '0;
        if (bypass_hit) begin
            rdata = rsp_data;
        end else if (count_q != '0) begin
            rdata = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            live_q    <= '0;
            stale_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            live_q    <= live_d;
            stale_q   <= stale_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign count     = count_q;
    assign live_out  = live_q;
    assign stale_out = stale_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// tb/tb_fetch_inst_buffer.sv - self-checking bench for fetch_inst_buffer
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_fetch_inst_buffer;
    localparam int WIDTH   = 97;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 4;
    localparam int CW      = $clog2(DEPTH + 1);

    logic             CLK = 1'b0;
    logic             RSTN;
    logic             req_valid, rsp_valid, flush, ren;
    logic [WIDTH-1:0] rsp_data;
    logic             req_ready, rok, rsp_err;
    logic [WIDTH-1:0] rdata;
    logic [CW-1:0]    count, live_out, stale_out;

    logic             b_req_valid, b_rsp_valid, b_flush, b_ren;
    logic [WIDTH-1:0] b_rsp_data;
    logic             b_req_ready, b_rok, b_rsp_err;
    logic [WIDTH-1:0] b_rdata;
    logic [CW-1:0]    b_count, b_live_out, b_stale_out;

    int errors = 0;
    int checks = 0;

    fetch_inst_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .BYPASS(0)) dut (
        .CLK(CLK), .RSTN(RSTN), .req_valid(req_valid), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flush(flush), .ren(ren),
        .rok(rok), .rdata(rdata), .count(count), .live_out(live_out),
        .stale_out(stale_out), .rsp_err(rsp_err)
    );

    fetch_inst_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .BYPASS(1)) dut_b (
        .CLK(CLK), .RSTN(RSTN), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .flush(b_flush), .ren(b_ren),
        .rok(b_rok), .rdata(b_rdata), .count(b_count), .live_out(b_live_out),
        .stale_out(b_stale_out), .rsp_err(b_rsp_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        req_valid = 1'b0; rsp_valid = 1'b0; flush = 1'b0; ren = 1'b0; rsp_data = '0;
        b_req_valid = 1'b0; b_rsp_valid = 1'b0; b_flush = 1'b0; b_ren = 1'b0; b_rsp_data = '0;
    endtask

    task automatic pulse_reset;
        idle();
        RSTN = 1'b0;
        tick();
        tick();
        RSTN = 1'b1;
        tick();
    endtask

    function automatic logic [WIDTH-1:0] rnd_entry();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[WIDTH-1:0];
    endfunction

    task automatic test_reset;
        idle();
        RSTN = 1'b0;
        #2;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%0b exp=0", req_ready); end
        checks++; if (rok !== 1'b0) begin errors++; $display("FAIL reset_rok got=%0b exp=0", rok); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%0h exp=0", rdata); end
        checks++; if (count !== '0 || live_out !== '0 || stale_out !== '0) begin errors++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", count, live_out, stale_out); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%0b exp=0", rsp_err); end
        tick();
        RSTN = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%0b exp=1", req_ready); end
    endtask

    task automatic test_fill;
        logic [WIDTH-1:0] d [4];
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; #1;
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got=%0b exp=1", i, req_ready); end
            tick();
        end
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_live4 got=%0b exp=0", req_ready); end
        checks++; if (live_out !== CW'(4)) begin errors++; $display("FAIL fill_live got=%0d exp=4", live_out); end
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d[i] = rnd_entry();
            rsp_valid = 1'b1; rsp_data = d[i];
            tick();
        end
        rsp_valid = 1'b0; #1;
        checks++; if (count !== CW'(4) || live_out !== '0) begin errors++; $display("FAIL fill_full got=%0d/%0d exp=4/0", count, live_out); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full got=%0b exp=0", req_ready); end
        checks++; if (rok !== 1'b1 || rdata !== d[0]) begin errors++; $display("FAIL fill_head got=%0b/%0h exp=1/%0h", rok, rdata, d[0]); end
        ren = 1'b1;
        tick();
        ren = 1'b0; #1;
        checks++; if (count !== CW'(3) || req_ready !== 1'b1) begin errors++; $display("FAIL fill_pop1 got=%0d/%0b exp=3/1", count, req_ready); end
        checks++; if (rdata !== d[1]) begin errors++; $display("FAIL fill_head2 got=%0h exp=%0h", rdata, d[1]); end
        ren = 1'b1;
        tick(); tick(); tick();
        ren = 1'b0; #1;
        checks++; if (count !== '0 || rok !== 1'b0) begin errors++; $display("FAIL fill_drain got=%0d/%0b exp=0/0", count, rok); end
    endtask

    task automatic test_order;
        logic [31:0] inst;
        logic [31:0] exp_inst;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) begin
                req_valid = 1'b1;
                tick();
            end
            req_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                inst = 32'h13 + 32'h80 * 32'(3 * r + i);
                rsp_valid = 1'b1; rsp_data = {65'h0, inst};
                tick();
            end
            rsp_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                exp_inst = 32'h13 + 32'h80 * 32'(3 * r + i);
                ren = 1'b1; #1;
                checks++; if (rok !== 1'b1 || rdata !== {65'h0, exp_inst}) begin errors++; $display("FAIL order_r%0d_i%0d got=%0b/%0h exp=1/%0h", r, i, rok, rdata, exp_inst); end
                tick();
            end
            ren = 1'b0;
        end
        #1;
        checks++; if (count !== '0 || live_out !== '0) begin errors++; $display("FAIL order_end got=%0d/%0d exp=0/0", count, live_out); end
    endtask

    task automatic test_flush;
        logic [WIDTH-1:0] d;
        req_valid = 1'b1; tick(); tick();
        req_valid = 1'b1; flush = 1'b1; rsp_valid = 1'b1; rsp_data = rnd_entry(); #1;
        checks++; if (req_ready !== 1'b0 || rok !== 1'b0) begin errors++; $display("FAIL flush_cycle got=%0b/%0b exp=0/0", req_ready, rok); end
        tick();
        req_valid = 1'b0; flush = 1'b0; rsp_valid = 1'b0; #1;
        checks++; if (stale_out !== CW'(1) || count !== '0 || live_out !== '0) begin errors++; $display("FAIL flush_after got=%0d/%0d/%0d exp=1/0/0", stale_out, count, live_out); end
        rsp_valid = 1'b1; rsp_data = rnd_entry();
        tick();
        rsp_valid = 1'b0; #1;
        checks++; if (stale_out !== '0 || count !== '0) begin errors++; $display("FAIL flush_drop got=%0d/%0d exp=0/0", stale_out, count); end
        req_valid = 1'b1; tick();
        req_valid = 1'b0; d = rnd_entry(); rsp_valid = 1'b1; rsp_data = d; tick();
        rsp_valid = 1'b0; #1;
        checks++; if (count !== CW'(1) || rdata !== d) begin errors++; $display("FAIL flush_new got=%0d/%0h exp=1/%0h", count, rdata, d); end
        ren = 1'b1; tick(); ren = 1'b0;
        req_valid = 1'b1; tick(); tick();
        req_valid = 1'b0; flush = 1'b1; tick();
        flush = 1'b0; req_valid = 1'b1; tick();
        req_valid = 1'b0; flush = 1'b1; tick();
        flush = 1'b0; #1;
        checks++; if (stale_out !== CW'(3) || live_out !== '0) begin errors++; $display("FAIL flush_accum got=%0d/%0d exp=3/0", stale_out, live_out); end
        rsp_valid = 1'b1; tick(); tick(); tick();
        rsp_valid = 1'b0; #1;
        checks++; if (stale_out !== '0 || count !== '0 || rsp_err !== 1'b0) begin errors++; $display("FAIL flush_drain got=%0d/%0d/%0b exp=0/0/0", stale_out, count, rsp_err); end
    endtask

    task automatic test_simultaneous;
        req_valid = 1'b1; tick(); tick(); tick();
        req_valid = 1'b0; rsp_valid = 1'b1; rsp_data = rnd_entry(); tick();
        rsp_data = rnd_entry(); tick();
        req_valid = 1'b1; rsp_valid = 1'b1; ren = 1'b1; rsp_data = rnd_entry(); #1;
        checks++; if (req_ready !== 1'b1 || rok !== 1'b1) begin errors++; $display("FAIL simul_pre got=%0b/%0b exp=1/1", req_ready, rok); end
        tick();
        idle(); #1;
        checks++; if (count !== CW'(2) || live_out !== CW'(1)) begin errors++; $display("FAIL simul_after got=%0d/%0d exp=2/1", count, live_out); end
        rsp_valid = 1'b1; tick();
        rsp_valid = 1'b0; ren = 1'b1; tick(); tick(); tick();
        ren = 1'b0; #1;
        checks++; if (count !== '0 || live_out !== '0) begin errors++; $display("FAIL simul_drain got=%0d/%0d exp=0/0", count, live_out); end
    endtask

    task automatic test_bypass;
        logic [WIDTH-1:0] d;
        b_req_valid = 1'b1; tick();
        b_req_valid = 1'b0; b_rsp_valid = 1'b1; b_rsp_data = {65'h0, 32'hdeadbeef}; b_ren = 1'b1; #1;
        checks++; if (b_rok !== 1'b1 || b_rdata !== {65'h0, 32'hdeadbeef}) begin errors++; $display("FAIL bypass_same_cycle got=%0b/%0h exp=1/deadbeef", b_rok, b_rdata); end
        tick();
        b_rsp_valid = 1'b0; b_ren = 1'b0; #1;
        checks++; if (b_count !== '0 || b_live_out !== '0 || b_rok !== 1'b0) begin errors++; $display("FAIL bypass_after got=%0d/%0d/%0b exp=0/0/0", b_count, b_live_out, b_rok); end
        b_req_valid = 1'b1; tick();
        d = rnd_entry();
        b_req_valid = 1'b0; b_rsp_valid = 1'b1; b_rsp_data = d; #1;
        checks++; if (b_rok !== 1'b0) begin errors++; $display("FAIL bypass_noren_rok got=%0b exp=0", b_rok); end
        tick();
        b_rsp_valid = 1'b0; #1;
        checks++; if (b_count !== CW'(1) || b_rok !== 1'b1 || b_rdata !== d) begin errors++; $display("FAIL bypass_stored got=%0d/%0b/%0h exp=1/1/%0h", b_count, b_rok, b_rdata, d); end
        b_ren = 1'b1; tick(); b_ren = 1'b0;
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] q [$];
        logic [WIDTH-1:0] d;
        int  live, stale;
        bit  rv, sv, fl, rn, exp_ready, exp_rok;
        live = 0; stale = 0;
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            rv = ($urandom_range(0, 1) == 1);
            fl = ($urandom_range(0, 19) == 0);
            rn = ($urandom_range(0, 2) != 0);
            sv = (live + stale > 0) && ($urandom_range(0, 2) != 0);
            d  = rnd_entry();
            req_valid = rv; rsp_valid = sv; rsp_data = d; flush = fl; ren = rn; #1;
            exp_ready = !fl && (q.size() + live < DEPTH) && (live + stale < MAX_OUT);
            exp_rok   = !fl && (q.size() > 0);
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c=%0d got=%0b exp=%0b", c, req_ready, exp_ready); end
            checks++; if (rok !== exp_rok) begin errors++; $display("FAIL rand_rok c=%0d got=%0b exp=%0b", c, rok, exp_rok); end
            checks++; if (count !== CW'(q.size()) || live_out !== CW'(live) || stale_out !== CW'(stale)) begin errors++; $display("FAIL rand_counters c=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c, count, live_out, stale_out, q.size(), live, stale); end
            if (exp_rok) begin
                checks++; if (rdata !== q[0]) begin errors++; $display("FAIL rand_rdata c=%0d got=%0h exp=%0h", c, rdata, q[0]); end
            end
            if (fl) begin
                stale = stale + live - (sv ? 1 : 0);
                live  = 0;
                q.delete();
            end else begin
                if (rn && exp_rok) void'(q.pop_front());
                if (sv) begin
                    if (stale > 0) stale--;
                    else begin live--; q.push_back(d); end
                end
                if (rv && exp_ready) live++;
            end
            tick();
        end
        idle(); #1;
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rand_err got=%0b exp=0", rsp_err); end
    endtask

    task automatic test_spurious_and_reset;
        pulse_reset();
        rsp_valid = 1'b1; rsp_data = rnd_entry(); tick();
        rsp_valid = 1'b0; #1;
        checks++; if (rsp_err !== 1'b1 || count !== '0) begin errors++; $display("FAIL spurious got=%0b/%0d exp=1/0", rsp_err, count); end
        req_valid = 1'b1; tick(); tick(); tick();
        req_valid = 1'b0; rsp_valid = 1'b1; rsp_data = rnd_entry(); tick();
        rsp_valid = 1'b0;
        RSTN = 1'b0; #1;
        checks++; if (count !== '0 || live_out !== '0 || stale_out !== '0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL midreset got=%0d/%0d/%0d/%0b/%0b exp=0/0/0/0/0", count, live_out, stale_out, rsp_err, req_ready); end
        tick();
        RSTN = 1'b1; tick();
        rsp_valid = 1'b1; tick();
        rsp_valid = 1'b0; #1;
        checks++; if (rsp_err !== 1'b1 || count !== '0) begin errors++; $display("FAIL post_reset_rsp got=%0b/%0d exp=1/0", rsp_err, count); end
    endtask

    initial begin
        fork
            begin
                #200000;
                $display("FAIL timeout got=running exp=finished");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_fill();
        test_order();
        test_flush();
        test_simultaneous();
        test_bypass();
        test_random();
        test_spurious_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
